serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial adder sequencer. It drives a single 1-bit full adder (`fa`) over WIDTH consecutive cycles to add two WIDTH-bit operands LSB-first, carrying through a flop between cycles. It presents a start/busy/done handshake to the requester and holds the result until the next operation. It sits between a control FSM or bus register and the shared `fa` cell, replacing a WIDTH-wide ripple adder where area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  reset
- start  in  1  request; sampled only when not busy
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- cin  in  1  carry-in; captured on accepted start
- busy  out  1  high while a sum is being computed
- done  out  1  one-cycle pulse when the result becomes valid
- sum  out  WIDTH  result; held stable from done until the next accepted start
- cout  out  1  final carry; same validity as sum

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - DONE
- IDLE: start=1 -> capture a, b into shift registers sa, sb; carry flop c<=cin; bit counter cnt<=0; go to RUN. start=0 -> stay.
- RUN, each cycle:
  - `fa` inputs are sa[0], sb[0], c.
  - sa, sb shift right by one.
  - The `fa` sum bit shifts into sum_r[WIDTH-1]; sum_r shifts right.
  - c <= `fa` cout.
  - cnt increments.
  - When cnt==WIDTH-1 at the edge, go to DONE.
- DONE: done=1 for exactly this cycle. sum=sum_r, cout=c.
  - start=1 -> accepted exactly as in IDLE and go to RUN. Back-to-back operations are allowed, with no idle cycle.
  - start=0 -> IDLE.
- start while in RUN is ignored. No queuing. Operands are not re-sampled.
- a, b, cin may change freely after the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- busy = (state==RUN). done = (state==DONE).

## Timing
- Reset values:
  - state=IDLE
  - busy=0, done=0
  - sum=0, cout=0
  - internal sa, sb, c, cnt = 0
- Reset mid-RUN aborts the operation. The next cycle shows the reset values, and no done pulse is produced for the aborted operation.
- Latency: start accepted at edge k. busy is high for cycles k+1..k+WIDTH. done is high in cycle k+WIDTH+1, and sum/cout are valid from that cycle.
- Throughput: one result per WIDTH+1 cycles with start held high.
- The sum/cout outputs hold the previous result through RUN, and update only on the edge entering DONE. Implement this by registering sum/cout from sum_r/c on the RUN->DONE transition, not by exposing the partial sum_r.
- cnt width is $clog2(WIDTH). Wrap-around is never reached because the state leaves RUN at WIDTH-1.
- rst has priority over start on the same edge.

## Structure
- Shared package `adder_pkg`:
  - state typedef {IDLE, RUN, DONE}
  - localparam for the counter width function
- One sub-module: instantiate the existing `fa` (itself built from `ha`) as the per-bit datapath. Do not inline the full-adder logic.
- Control FSM, shift registers, carry flop and counter live in serial_add_ctrl.

## Test plan
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start pulsed -> busy high 8 cycles, then done pulse on cycle 9 after start, with sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start held high with operands 1+2, then 3+4 changed right after the first accept:
  - done pulses 9 cycles apart
  - results 8'h03, then 8'h07
  - no IDLE cycle between the two operations
- start pulsed on the 3rd RUN cycle with different operands -> ignored. Result equals the first operands' sum, and busy length is unchanged.
- rst asserted on the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, and no done pulse follows. A new start then completes normally.
- Exhaustive WIDTH=2 sweep, all 32 combinations of a, b, cin -> {cout,sum}==a+b+cin for every case, with done exactly once per start.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared types and sizing helpers for the bit-serial adder.
// Revision : 1.0
// ============================================================================
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fa.sv
`default_nettype none
// ============================================================================
// Module   : ha / fa
// Brief    : Half adder and the full adder built from two of them.
// Revision : 1.0
// ============================================================================
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  ha u_ha0 (.a(a),    .b(b),  .s(w_s0), .c(w_c0));
  ha u_ha1 (.a(w_s0), .b(ci), .s(s),    .c(w_c1));

  assign co = w_c0 | w_c1;
endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Sequences one shared full adder over WIDTH cycles, LSB first.
// Revision : 1.0
// ============================================================================
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_fa_s;
  logic             w_fa_co;
  logic             w_accept;
  logic             w_last;

  fa u_fa (
    .a  (r_sa[0]),
    .b  (r_sb[0]),
    .ci (r_c),
    .s  (w_fa_s),
    .co (w_fa_co)
  );

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_cnt == c_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == c_LAST) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_c      <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sa  <= a;
        r_sb  <= b;
        r_c   <= cin;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
        r_sum_sh <= {w_fa_s, r_sum_sh[WIDTH-1:1]};
        r_c      <= w_fa_co;
        r_cnt    <= r_cnt + 1'b1;
      end
      // The final bit lands on this same edge, so capture from the adder directly.
      if (w_last) begin
        r_sum  <= {w_fa_s, r_sum_sh[WIDTH-1:1]};
        r_cout <= w_fa_co;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire
